// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris matrix executors.
package tetris_pkg;

    typedef enum logic [1:0] {
        eIDLE  = 2'd0,
        eShift = 2'd1,
        eFill  = 2'd2,
        eDone  = 2'd3
    } rise_state_e;

    localparam int max_rows_default_c = 4;
    localparam int row_width_c        = 16;

    typedef logic [row_width_c-1:0] row_t;

endpackage

// File: rtl/tetris_garbage_row.sv
// Combinational garbage-line generator: all ones with the hole column cleared.
module tetris_garbage_row #(
    parameter int width_p = 16
) (
    input  logic [$clog2(width_p)-1:0] hole_i,
    output logic [width_p-1:0]         row_o
);

    localparam int hole_w_lp = $clog2(width_p);

    // A hole index beyond the row width matches no column, leaving a full row.
    for (genvar gi = 0; gi < width_p; gi++) begin : g_bit
        assign row_o[gi] = (hole_i != hole_w_lp'(gi));
    end

endmodule

// File: rtl/executor_rise.sv
// Garbage-line inserter: shifts the matrix up by N rows, then fills the bottom
// N rows with garbage lines, flagging overflow if a non-empty row is lost.
module executor_rise
    import tetris_pkg::*;
#(
    parameter int width_p    = 16,
    parameter int height_p   = 32,
    parameter int max_rows_p = max_rows_default_c,
    parameter int debug_p    = 0
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        v_i,
    input  logic [2:0]                  rows_i,
    input  logic [$clog2(width_p)-1:0]  hole_i,
    output logic                        ready_o,
    output logic                        done_o,
    output logic                        overflow_o,
    output logic [$clog2(height_p)-1:0] mm_read_addr_o,
    input  logic [width_p-1:0]          mm_read_data_i,
    output logic [$clog2(height_p)-1:0] mm_write_addr_o,
    output logic [width_p-1:0]          mm_write_data_o,
    output logic                        mm_write_v_o
);

    localparam int addr_w_lp = $clog2(height_p);
    localparam int hole_w_lp = $clog2(width_p);

    rise_state_e            state_r, state_n;
    logic [addr_w_lp-1:0]   index_r, index_n;
    logic [2:0]             rows_r, rows_n;
    logic [hole_w_lp-1:0]   hole_r, hole_n;
    logic                   overflow_r, overflow_n;

    logic [addr_w_lp-1:0]   rows_ext;
    logic                   last_row;
    logic [width_p-1:0]     garbage_row;

    assign rows_ext = addr_w_lp'(rows_r);
    assign last_row = (index_r == addr_w_lp'(height_p - 1));

    tetris_garbage_row #(
        .width_p (width_p)
    ) garbage (
        .hole_i (hole_r),
        .row_o  (garbage_row)
    );

    always_comb begin
        state_n    = state_r;
        index_n    = index_r;
        rows_n     = rows_r;
        hole_n     = hole_r;
        overflow_n = overflow_r;
        case (state_r)
            eIDLE: begin
                if (v_i) begin
                    rows_n     = (int'(rows_i) > max_rows_p) ? 3'(max_rows_p) : rows_i;
                    hole_n     = hole_i;
                    overflow_n = 1'b0;
                    index_n    = '0;
                    state_n    = (rows_n != 3'd0) ? eShift : eDone;
                end
            end
            eShift: begin
                // Top rows with index below N have no destination; losing one with data is overflow.
                if ((index_r < rows_ext) && (mm_read_data_i != '0)) begin
                    overflow_n = 1'b1;
                end
                if (last_row) begin
                    index_n = addr_w_lp'(height_p) - rows_ext;
                    state_n = eFill;
                end else begin
                    index_n = index_r + addr_w_lp'(1);
                end
            end
            eFill: begin
                if (last_row) begin
                    state_n = eDone;
                end else begin
                    index_n = index_r + addr_w_lp'(1);
                end
            end
            eDone: begin
                state_n = eIDLE;
            end
            default: begin
                state_n = eIDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= eIDLE;
            index_r    <= '0;
            rows_r     <= '0;
            hole_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            index_r    <= index_n;
            rows_r     <= rows_n;
            hole_r     <= hole_n;
            overflow_r <= overflow_n;
        end
    end

    // Ascending shift order reads every source row before it is overwritten.
    assign ready_o         = (state_r == eIDLE);
    assign done_o          = (state_r == eDone);
    assign overflow_o      = overflow_r;
    assign mm_read_addr_o  = index_r;
    assign mm_write_v_o    = ((state_r == eShift) && (index_r >= rows_ext)) || (state_r == eFill);
    assign mm_write_addr_o = (state_r == eShift) ? (index_r - rows_ext) : index_r;
    assign mm_write_data_o = (state_r == eFill) ? garbage_row : mm_read_data_i;

endmodule

// File: tb/tb_executor_rise.sv
// Directed bench for executor_rise with a behavioural matrix memory.
module tb_executor_rise;

    localparam int W  = 16;
    localparam int H  = 32;
    localparam int AW = 5;
    localparam int HW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          v = 1'b0;
    logic [2:0]    rows = '0;
    logic [HW-1:0] hole = '0;
    logic          ready, done, overflow, mm_write_v;
    logic [AW-1:0] mm_read_addr, mm_write_addr;
    logic [W-1:0]  mm_read_data, mm_write_data;

    logic [W-1:0]  mem [H];
    int            tests = 0;
    int            fails = 0;
    int            wr_count = 0;
    int            wr_hi = 0;

    always #5 clk = ~clk;

    executor_rise #(
        .width_p    (W),
        .height_p   (H),
        .max_rows_p (4),
        .debug_p    (0)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .v_i             (v),
        .rows_i          (rows),
        .hole_i          (hole),
        .ready_o         (ready),
        .done_o          (done),
        .overflow_o      (overflow),
        .mm_read_addr_o  (mm_read_addr),
        .mm_read_data_i  (mm_read_data),
        .mm_write_addr_o (mm_write_addr),
        .mm_write_data_o (mm_write_data),
        .mm_write_v_o    (mm_write_v)
    );

    assign mm_read_data = mem[mm_read_addr];

    always @(posedge clk) begin
        if (mm_write_v) begin
            mem[mm_write_addr] = mm_write_data;
            wr_count++;
            if (int'(mm_write_addr) >= H - 4) wr_hi++;
        end
    end

    task automatic clear_mem();
        @(negedge clk);
        for (int i = 0; i < H; i++) mem[i] = '0;
        wr_count = 0;
        wr_hi    = 0;
    endtask

    // Drive one request; returns #1 after the accept edge.
    task automatic start_op(input logic [2:0] r, input logic [HW-1:0] h);
        @(negedge clk);
        v    = 1'b1;
        rows = r;
        hole = h;
        @(posedge clk);
        #1;
        v = 1'b0;
    endtask

    // Latency counted in edges from accept to the edge that samples done_o high.
    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                lat = k + 1;
                ok  = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        tests++;
        if (ready !== 1'b1 || done !== 1'b0 || overflow !== 1'b0 || mm_write_v !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got ready=%b done=%b ovf=%b wv=%b, want 1 0 0 0",
                     ready, done, overflow, mm_write_v);
        end
        @(negedge clk);
        reset = 1'b0;
        $display("[TB] reset released");
    endtask

    task automatic test_empty_fill();
        int lat; bit ok; int nz;
        clear_mem();
        start_op(3'd2, 4'd5);
        wait_done(lat, ok);
        tests++;
        if (!ok || lat != 35) begin
            fails++;
            $display("FAIL empty_latency: got %0d (ok=%b), want 35", lat, ok);
        end
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL empty_ready_with_done: got ready=%b, want 0", ready);
        end
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL empty_overflow: got %b, want 0", overflow);
        end
        @(negedge clk);
        tests++;
        if (mem[30] !== 16'hFFDF || mem[31] !== 16'hFFDF) begin
            fails++;
            $display("FAIL empty_fill_rows: got %h %h, want ffdf ffdf", mem[30], mem[31]);
        end
        nz = 0;
        for (int i = 0; i < 30; i++) if (mem[i] !== '0) nz++;
        tests++;
        if (nz != 0) begin
            fails++;
            $display("FAIL empty_upper_rows: got %0d non-zero rows, want 0", nz);
        end
        tests++;
        if (wr_count != 32) begin
            fails++;
            $display("FAIL empty_write_count: got %0d, want 32", wr_count);
        end
        $display("[TB] empty fill rows=2 hole=5 latency=%0d writes=%0d", lat, wr_count);
    endtask

    task automatic test_shift_pattern();
        int lat; bit ok; logic [W-1:0] exp;
        clear_mem();
        for (int i = 2; i < H; i++) mem[i] = W'(i);
        start_op(3'd2, 4'd0);
        wait_done(lat, ok);
        tests++;
        if (!ok || lat != 35) begin
            fails++;
            $display("FAIL shift_latency: got %0d (ok=%b), want 35", lat, ok);
        end
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL shift_overflow: got %b, want 0", overflow);
        end
        @(negedge clk);
        for (int j = 0; j < H; j++) begin
            exp = (j < 30) ? W'(j + 2) : 16'hFFFE;
            tests++;
            if (mem[j] !== exp) begin
                fails++;
                $display("FAIL shift_row%0d: got %h, want %h", j, mem[j], exp);
            end
        end
        $display("[TB] shift pattern rows=2 hole=0 latency=%0d", lat);
    endtask

    task automatic test_overflow();
        int lat; bit ok;
        clear_mem();
        mem[1] = 16'h0001;
        start_op(3'd3, 4'd0);
        wait_done(lat, ok);
        tests++;
        if (!ok || lat != 36 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_at_done: got lat=%0d ovf=%b, want 36 1", lat, overflow);
        end
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (overflow !== 1'b1 || ready !== 1'b1) begin
            fails++;
            $display("FAIL ovf_held: got ovf=%b ready=%b, want 1 1", overflow, ready);
        end
        tests++;
        if (mem[29] !== 16'hFFFE || mem[28] !== '0) begin
            fails++;
            $display("FAIL ovf_rows: got %h %h, want 0000 fffe", mem[28], mem[29]);
        end
        start_op(3'd0, 4'd0);
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_cleared: got %b, want 0", overflow);
        end
        wait_done(lat, ok);
        $display("[TB] overflow rows=3 flag held and cleared on next accept");
    endtask

    task automatic test_zero_rows();
        int lat; bit ok; int bad;
        clear_mem();
        for (int i = 0; i < H; i++) mem[i] = W'(i * 3 + 1);
        start_op(3'd0, 4'd7);
        wait_done(lat, ok);
        tests++;
        if (!ok || lat != 1) begin
            fails++;
            $display("FAIL zero_latency: got %0d (ok=%b), want 1", lat, ok);
        end
        @(posedge clk);
        #1;
        tests++;
        if (wr_count != 0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL zero_writes: got writes=%0d ready=%b, want 0 1", wr_count, ready);
        end
        bad = 0;
        for (int i = 0; i < H; i++) if (mem[i] !== W'(i * 3 + 1)) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL zero_unchanged: got %0d changed rows, want 0", bad);
        end
        $display("[TB] zero rows latency=%0d writes=%0d", lat, wr_count);
    endtask

    task automatic test_saturate();
        int lat; bit ok;
        clear_mem();
        for (int i = 0; i < H; i++) mem[i] = W'(i);
        start_op(3'd7, 4'd9);
        wait_done(lat, ok);
        tests++;
        if (!ok || lat != 37) begin
            fails++;
            $display("FAIL sat_latency: got %0d (ok=%b), want 37", lat, ok);
        end
        @(negedge clk);
        tests++;
        if (wr_count != 32 || wr_hi != 4) begin
            fails++;
            $display("FAIL sat_writes: got total=%0d fill=%0d, want 32 4", wr_count, wr_hi);
        end
        tests++;
        if (mem[0] !== 16'd4 || mem[27] !== 16'd31 || mem[28] !== 16'hFDFF || mem[31] !== 16'hFDFF) begin
            fails++;
            $display("FAIL sat_rows: got %h %h %h %h, want 0004 001f fdff fdff",
                     mem[0], mem[27], mem[28], mem[31]);
        end
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL sat_overflow: got %b, want 1", overflow);
        end
        $display("[TB] saturate rows=7 latency=%0d writes=%0d", lat, wr_count);
    endtask

    task automatic test_reset_mid_op();
        clear_mem();
        start_op(3'd2, 4'd0);
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (mm_read_addr !== 5'd10 || mm_write_v !== 1'b1) begin
            fails++;
            $display("FAIL midop_index: got addr=%0d wv=%b, want 10 1", mm_read_addr, mm_write_v);
        end
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if (mm_write_v !== 1'b0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL midop_async: got wv=%b ready=%b, want 0 1", mm_write_v, ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (ready !== 1'b1 || done !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL midop_release: got ready=%b done=%b ovf=%b, want 1 0 0", ready, done, overflow);
        end
        $display("[TB] reset mid-shift at index 10");
    endtask

    task automatic test_busy_v();
        int lat; bit ok;
        clear_mem();
        start_op(3'd2, 4'd3);
        lat = 0;
        ok  = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k == 3) begin
                v    = 1'b1;
                rows = 3'd0;
                hole = 4'd1;
            end
            if (k == 5) v = 1'b0;
            if (done) begin
                lat = k + 1;
                ok  = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        v = 1'b0;
        tests++;
        if (!ok || lat != 35) begin
            fails++;
            $display("FAIL busy_latency: got %0d (ok=%b), want 35", lat, ok);
        end
        @(negedge clk);
        tests++;
        if (mem[30] !== 16'hFFF7 || mem[31] !== 16'hFFF7 || wr_count != 32) begin
            fails++;
            $display("FAIL busy_result: got %h %h writes=%0d, want fff7 fff7 32", mem[30], mem[31], wr_count);
        end
        $display("[TB] v pulsed while busy ignored latency=%0d", lat);
    endtask

    initial begin
        for (int i = 0; i < H; i++) mem[i] = '0;
        test_reset();
        test_empty_fill();
        test_shift_pattern();
        test_overflow();
        test_zero_rows();
        test_saturate();
        test_reset_mid_op();
        test_busy_v();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
